theory_divider_param: RTL
=========================

# theory_divider_param

Parametrised multi-cycle restoring divider and the next generation of the team's fixed 32-bit theory divider. It computes one quotient bit per clock over a WIDTH-bit operand pair and supports an optional signed mode. It flags division by zero and the signed-overflow case. It keeps the start/done handshake that existing masters already drive, so it can replace the 32-bit block wherever a divider is instantiated.

## Interface
- WIDTH, 32: operand and result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, do not override.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start_sig  in  1  request; the master holds it high until it sees done_sig, then drops it.
- signed_mode  in  1  1 = two's-complement operands; sampled with the operands.
- dividend  in  WIDTH  numerator; sampled only on acceptance.
- divisor  in  WIDTH  denominator; sampled only on acceptance.
- busy  out  1  high from acceptance until done_sig falls.
- done_sig  out  1  one-cycle pulse; results are valid in this cycle and hold afterwards.
- quotient  out  WIDTH  result quotient.
- reminder  out  WIDTH  result remainder.
- div_zero  out  1  divisor was 0; valid with done_sig and held with the results.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_sig=1:
  - Latch the operands and signed_mode.
  - Form the magnitudes |dividend| and |divisor|, using magnitudes only if signed mode applies.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the WIDTH+1-bit partial remainder and set cnt=0.
  - Go to CALC.
- CALC, each cycle:
  - Shift {rem, q} left one bit and trial-subtract the divisor magnitude from rem.
  - If the difference is non-negative, keep it and set the q LSB to 1; otherwise restore.
  - Increment cnt. After WIDTH iterations go to FIX.
- FIX:
  - Negate q if neg_q; negate rem if neg_r. Truncating division: the remainder takes the sign of the dividend.
  - Write quotient, reminder and div_zero, then go to DONE.
- DONE: assert done_sig for this cycle and return to IDLE unconditionally.
- Divide by zero:
  - quotient = all ones, reminder = dividend as given, div_zero = 1.
  - Latency is unchanged; CALC still runs but its result is discarded.
- Signed overflow (most-negative value / -1): quotient = most-negative value, reminder = 0, div_zero = 0.
- The input operands, signed_mode and start_sig are ignored outside IDLE. Dropping start_sig mid-operation does not abort the operation.
- quotient, reminder and div_zero change only in FIX; they hold between operations.

## Timing
- Acceptance edge E0 (IDLE with start_sig=1). CALC occupies edges E1..E_WIDTH. FIX is edge E_WIDTH+1, so done_sig is high in the cycle following E_WIDTH+1.
- Latency: WIDTH+1 edges from acceptance to done_sig; WIDTH+2 edges of occupancy. For WIDTH=32, done_sig rises 33 edges after acceptance.
- start_sig is not sampled in DONE. A master that drops start_sig on the edge where it sees done_sig causes no restart.
- If start_sig is still high in IDLE after DONE, a new operation is accepted back-to-back.
- Reset values: done_sig=0, busy=0, div_zero=0, quotient=0, reminder=0, state=IDLE.
- Reset asserted mid-operation returns the block to IDLE on that edge. No done_sig is produced and the outputs return to 0.

## Configuration
- THEORY_DIV_SIGNED_EN defined:
  - The signed_mode input is honoured.
  - The magnitude, sign-fix and overflow logic are compiled in.
- THEORY_DIV_SIGNED_EN undefined:
  - signed_mode is ignored and every operation is unsigned.
  - FIX copies q and rem straight to the outputs.
  - Latency is identical in both builds.

## Test plan
- WIDTH=32, unsigned, 7/2 -> quotient=3, reminder=1, done_sig rises 33 edges after acceptance as a 1-cycle pulse.
- Unsigned 20512/2236 -> 9 r 388. Unsigned 1040000056/8999 -> 115568 r 3624.
- 0xFFFFCEEC/22:
  - Unsigned: 195225215 r 2.
  - Signed (macro defined): quotient=0xFFFFFDC5 (-571), reminder=0xFFFFFFFE (-2).
  - Signed request with the macro undefined: returns the unsigned result.
- 1234/0 -> quotient=0xFFFFFFFF, reminder=1234, div_zero=1. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, reminder=0, div_zero=0.
- Master holds start_sig until done_sig then drops it -> exactly one operation per request. Operands changed mid-operation -> the result reflects the latched values.
- Reset asserted at CALC cycle 10 -> next edge: IDLE, busy=0, outputs 0, no done_sig. A following 7/2 request -> 3 r 1. Repeat the first two scenarios with WIDTH=8 (200/7 -> 28 r 4, latency 9).

Source files
------------

// File: rtl/theory_divider_param.sv
// theory_divider_param: WIDTH-bit multi-cycle restoring divider, one quotient bit per clock.
// Optional signed mode compiled in with THEORY_DIV_SIGNED_EN. Rev 1.0.
`default_nettype none

module theory_divider_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_sig,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] reminder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;

  // The stored remainder is always below the divisor, so its WIDTH+1-th bit
  // only exists transiently in the shifted value.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

`ifdef THEORY_DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg   = signed_mode & dividend[WIDTH-1];
  assign w_b_neg   = signed_mode & divisor[WIDTH-1];
  assign w_dvd_mag = w_a_neg ? -dividend : dividend;
  assign w_dvs_mag = w_b_neg ? -divisor : divisor;
  // Most-negative / -1 falls out naturally: the magnitude 2^(WIDTH-1) negates to itself.
  assign w_q_fix   = r_neg_q ? -r_q : r_q;
  assign w_r_fix   = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && start_sig) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_sm;

  assign w_unused_sm = signed_mode;
  assign w_dvd_mag   = dividend;
  assign w_dvs_mag   = divisor;
  assign w_q_fix     = r_q;
  assign w_r_fix     = r_rem;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_q      <= '0;
      r_dvs    <= '0;
      r_dvd    <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done_sig <= 1'b0;
      quotient <= '0;
      reminder <= '0;
      div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done_sig <= 1'b0;
          if (start_sig) begin
            r_q     <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_dvd   <= dividend;
            r_zero  <= (divisor == '0);
            r_rem   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_zero) begin
            quotient <= '1;
            reminder <= r_dvd;
            div_zero <= 1'b1;
          end else begin
            quotient <= w_q_fix;
            reminder <= w_r_fix;
            div_zero <= 1'b0;
          end
          done_sig <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          done_sig <= 1'b0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
